// File: rtl/seven_seg_scan.sv
// Purpose : four-digit time-multiplexed seven-segment driver with per-frame snapshot and whole-display blink.
// Latency : an/seg/dp are registered, one cycle behind idx/snap/phase and the live blink_en/dp_mask inputs.
// Backpr. : none; the scan free-runs and nums is sampled only at frame boundaries, so no flow control exists.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   nums      packed digit codes, [15:12] = digit 3 (leftmost) .. [3:0] = digit 0 (rightmost)
//   blink_en  1 = blank the whole display during the blink "off" phase
//   dp_mask   bit i lights the decimal point of digit i (sampled live, not snapshotted)
//   an        anodes, active-low, one-hot-low while displaying
//   seg       segments, active-low, seg[0] = a .. seg[6] = g
//   dp        decimal point, active-low
//
// DIV must be >= 2 and BLINK_DIV >= 1.

module seven_seg_scan #(
    parameter int DIV       = 100000,
    parameter int BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] nums,
    input  logic        blink_en,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = $clog2(DIV);
    // A BLINK_DIV of 1 would give a zero-width counter; keep at least one bit.
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [15:0]   snap;

    logic          tick;
    logic [3:0]    code;
    logic [6:0]    seg_dec;
    logic [3:0]    an_dec;
    logic          disp_on;

    assign tick = (cnt == CNT_MAX);

    // ------------------------------------------------------------------
    // Refresh counter, digit index and snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= 2'd0;
            snap <= 16'hFFFF;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                // Load on the same edge idx wraps 3->0 so the whole next
                // frame comes from one coherent sample of nums.
                if (idx == 2'd3) begin
                    snap <= nums;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink timebase: runs regardless of blink_en so enabling blink
    // mid-stream lands on whatever phase is current.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            if (bcnt == BCNT_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit select and decode
    // ------------------------------------------------------------------
    always_comb begin
        code   = snap[3:0];
        an_dec = 4'b1110;
        case (idx)
            2'd0: begin code = snap[3:0];   an_dec = 4'b1110; end
            2'd1: begin code = snap[7:4];   an_dec = 4'b1101; end
            2'd2: begin code = snap[11:8];  an_dec = 4'b1011; end
            2'd3: begin code = snap[15:12]; an_dec = 4'b0111; end
            default: begin code = 4'hF;     an_dec = 4'b1111; end
        endcase
    end

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_dec = 7'b1111111;
        case (code)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0111111;   // dash: segment g only
            default: seg_dec = 7'b1111111;
        endcase
    end

    assign disp_on = ~(blink_en & ~phase);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (disp_on) begin
            an  <= an_dec;
            seg <= seg_dec;
            dp  <= ~dp_mask[idx];
        end else begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan at DIV=4, BLINK_DIV=2: a cycle-count reference
// model checks every cycle, table vectors check whole frames, and hand
// sequences cover mid-frame updates, blinking and reset mid-scan.

module tb_seven_seg_scan;

    localparam int DIV       = 4;
    localparam int BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] nums = 16'h0000;
    logic        blink_en = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIV(DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .nums     (nums),
        .blink_en (blink_en),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: edges since reset release and last captured frame.
    int          n = 0;
    logic [15:0] snapq = 16'hFFFF;
    logic [6:0]  seg_lut [16];
    logic [3:0]  an_tab [4];

    typedef struct {
        logic [15:0]     nums;
        logic [3:0]      dpm;
        logic [3:0][6:0] segs;   // [0] = digit 0 (rightmost)
        logic [3:0]      dpn;    // expected active-low dp per digit
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // One clock: model predicts the registered outputs from the inputs
    // present before the edge, then the DUT is compared #1 after it.
    task automatic step();
        logic [15:0] nv;
        logic        be;
        logic [3:0]  dm;
        logic [11:0] exp;
        int          ticks;
        int          di;
        logic        on;
        nv = nums;
        be = blink_en;
        dm = dp_mask;
        if (!rst_n) begin
            n     = 0;
            snapq = 16'hFFFF;
            exp   = 12'hFFF;
        end else begin
            n++;
            ticks = (n - 1) / DIV;
            di    = ticks % 4;
            on    = !(be && (((ticks / BLINK_DIV) % 2) == 1));
            if (on)
                exp = {an_tab[di], seg_lut[snapq[4*di +: 4]], ~dm[di]};
            else
                exp = 12'hFFF;
            if ((n % (4 * DIV)) == 0)
                snapq = nv;
        end
        @(posedge clk);
        #1;
        check("model", {an, seg, dp}, exp);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        step();
        step();
    endtask

    initial begin
        seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        vecs[0] = '{16'h1234, 4'b0000,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
        vecs[1] = '{16'hAAAA, 4'b0000,
                    {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b1111};
        vecs[2] = '{16'hFB0E, 4'b0000,
                    {7'b1111111, 7'b1111111, 7'b1000000, 7'b1111111}, 4'b1111};
        vecs[3] = '{16'h5678, 4'b0100,
                    {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1011};
        vecs[4] = '{16'h09C9, 4'b1001,
                    {7'b1000000, 7'b0010000, 7'b1111111, 7'b0010000}, 4'b0110};

        // Reset state.
        hold_reset();
        check("reset_state", {an, seg, dp}, 12'hFFF);

        // Table-driven frames: blank frame first, then the snapshot frame.
        for (int v = 0; v < 5; v++) begin
            hold_reset();
            nums     = vecs[v].nums;
            dp_mask  = vecs[v].dpm;
            blink_en = 1'b0;
            rst_n    = 1'b1;
            for (int k = 0; k < 16; k++) begin
                step();
                check("blank_frame", {an, seg, dp},
                      {an_tab[k/4], 7'h7F, vecs[v].dpn[k/4]});
            end
            for (int k = 0; k < 16; k++) begin
                step();
                check("frame", {an, seg, dp},
                      {an_tab[k/4], vecs[v].segs[k/4], vecs[v].dpn[k/4]});
            end
        end

        // nums changes while idx=1: current frame stays 0, next frame shows 9.
        hold_reset();
        nums = 16'h0000; dp_mask = 4'b0000; blink_en = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 21; k++) step();
        nums = 16'h9999;
        for (int k = 22; k <= 32; k++) begin
            step();
            check("no_tear", {an, seg, dp}, {an_tab[(k-17)/4], 7'b1000000, 1'b1});
        end
        for (int k = 33; k <= 48; k++) begin
            step();
            check("next_frame", {an, seg, dp}, {an_tab[(k-33)/4], 7'b0010000, 1'b1});
        end

        // Blink: 8 cycles on, 8 off; then blink_en=0 keeps it continuous.
        hold_reset();
        nums = 16'h1234; dp_mask = 4'b0100; blink_en = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) step();
        for (int k = 0; k < 16; k++) begin
            step();
            if (k < 8)
                check("blink_on", {an, seg, dp},
                      {an_tab[k/4], vecs[0].segs[k/4], (k/4 == 2) ? 1'b0 : 1'b1});
            else
                check("blink_off", {an, seg, dp}, 12'hFFF);
        end
        blink_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check("blink_dis", {an, seg, dp},
                  {an_tab[k/4], vecs[0].segs[k/4], (k/4 == 2) ? 1'b0 : 1'b1});
        end

        // Reset mid-slot of digit 2, then scan restarts at digit 0 blank.
        hold_reset();
        nums = 16'h1234; dp_mask = 4'b0000; blink_en = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 26; k++) step();
        check("pre_rst_slot2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
        rst_n = 1'b0;
        #1;
        check("async_rst", {an, seg, dp}, 12'hFFF);
        step();
        check("rst_hold", {an, seg, dp}, 12'hFFF);
        rst_n = 1'b1;
        step();
        check("restart_d0", {an, seg, dp}, {4'b1110, 7'h7F, 1'b1});
        for (int k = 2; k <= 16; k++) step();
        for (int k = 0; k < 16; k++) begin
            step();
            check("post_rst_frame", {an, seg, dp},
                  {an_tab[k/4], vecs[0].segs[k/4], 1'b1});
        end

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                if ($urandom_range(0, 7) == 0)  nums = 16'($urandom);
                if ($urandom_range(0, 36) == 0) blink_en = ~blink_en;
                if ($urandom_range(0, 22) == 0) dp_mask = 4'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
